io_port_arbiter: RTL and testbench

IO_PORT_ARBITER -- requirements
Module: io_port_arbiter

---
 rtl/io_port_arbiter_pkg.sv | 16 +
 rtl/rr_priority_select.sv | 30 +++
 rtl/io_port_arbiter.sv | 105 ++++++++++
 tb/tb_io_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_arbiter_pkg.sv
// rtl/io_port_arbiter_pkg.sv - shared arbiter FSM encoding and width helper
package io_port_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - rotate-from-pointer one-hot priority pick
module rr_priority_select #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  // Walk upward from ptr with wrap; the first requester seen wins.
  always_comb begin
    int pos;
    pos       = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!any && req[pos[PW-1:0]]) begin
        grant[pos[PW-1:0]] = 1'b1;
        grant_idx          = pos[PW-1:0];
        any                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_port_arbiter.sv
// rtl/io_port_arbiter.sv - round-robin arbiter with burst lock onto one write port
module io_port_arbiter
  import io_port_arbiter_pkg::*;
#(
  parameter int REQ_COUNT   = 4,
  parameter int WORD_WIDTH  = 36,
  parameter int STALL_WIDTH = 16
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [REQ_COUNT-1:0]            req_valid,
  input  logic [REQ_COUNT-1:0]            req_lock,
  input  logic [REQ_COUNT*WORD_WIDTH-1:0] req_data,
  output logic [REQ_COUNT-1:0]            req_ready,
  input  logic                            port_full,
  output logic                            port_wren,
  output logic [WORD_WIDTH-1:0]           port_data,
  output logic [clog2(REQ_COUNT)-1:0]     owner,
  output logic                            locked,
  output logic [STALL_WIDTH-1:0]          stall_count
);

  localparam int PW = clog2(REQ_COUNT);
  localparam logic [PW-1:0] LAST_IDX = PW'(REQ_COUNT - 1);

  arb_state_t           state, state_next;
  logic [PW-1:0]        rr_ptr, rr_ptr_next;
  logic [PW-1:0]        sel, rr_idx;
  logic [REQ_COUNT-1:0] rr_grant;
  logic                 rr_any, sel_valid, handshake, stall_hit;
  logic [WORD_WIDTH-1:0] words [REQ_COUNT];

  for (genvar g = 0; g < REQ_COUNT; g++) begin : g_words
    assign words[g] = req_data[g*WORD_WIDTH +: WORD_WIDTH];
  end

  rr_priority_select #(
    .N  (REQ_COUNT),
    .PW (PW)
  ) u_rr_select (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any       (rr_any)
  );

  // While locked only the owner is a candidate; otherwise the round-robin pick.
  always_comb begin
    sel       = rr_idx;
    sel_valid = rr_any;
    req_ready = '0;
    if (state == LOCKED) begin
      sel       = owner;
      sel_valid = req_valid[owner];
    end
    if (reset_n && !port_full && sel_valid) begin
      req_ready = (state == LOCKED) ? (REQ_COUNT'(1) << owner) : rr_grant;
    end
  end

  assign handshake = reset_n && sel_valid && !port_full;
  assign stall_hit = sel_valid && port_full;
  assign locked    = (state == LOCKED);

  always_comb begin
    state_next  = state;
    rr_ptr_next = rr_ptr;
    if (handshake) begin
      state_next = req_lock[sel] ? LOCKED : IDLE;
      if (!req_lock[sel]) begin
        rr_ptr_next = (sel == LAST_IDX) ? '0 : sel + PW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner       <= '0;
      port_wren   <= 1'b0;
      port_data   <= '0;
      stall_count <= '0;
    end else begin
      port_wren <= handshake;
      if (handshake) begin
        owner     <= sel;
        port_data <= words[sel];
      end
      if (stall_hit && stall_count != '1) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_port_arbiter.sv
// tb/tb_io_port_arbiter.sv - randomized and directed checks against a reference model
module tb_io_port_arbiter;

  localparam int N  = 4;
  localparam int W  = 36;
  localparam int SW = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic           clock;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_lock;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           port_full;
  logic           port_wren;
  logic [W-1:0]   port_data;
  logic [1:0]     owner;
  logic           locked;
  logic [SW-1:0]  stall_count;

  logic [W-1:0] words [N];

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;

  int           m_locked = 0;
  int           m_owner  = 0;
  int           m_rr     = 0;
  int           m_stall  = 0;
  bit           m_wren   = 0;
  logic [W-1:0] m_data   = '0;

  io_port_arbiter #(
    .REQ_COUNT   (N),
    .WORD_WIDTH  (W),
    .STALL_WIDTH (SW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_lock    (req_lock),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .port_full   (port_full),
    .port_wren   (port_wren),
    .port_data   (port_data),
    .owner       (owner),
    .locked      (locked),
    .stall_count (stall_count)
  );

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = words[i];
  end

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Which requester may hand over a word right now, or -1 if none.
  function automatic int pick(input logic [N-1:0] v);
    if (m_locked != 0) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_locked = 0; m_owner = 0; m_rr = 0; m_stall = 0; m_wren = 0; m_data = '0;
    end else begin : model_step
      int c;
      c = pick(req_valid);
      m_wren = 0;
      if (c >= 0 && port_full) begin
        if (m_stall < SMAX) m_stall++;
      end else if (c >= 0) begin
        m_wren  = 1;
        m_data  = words[c];
        m_owner = c;
        if (req_lock[c]) m_locked = 1;
        else begin
          m_locked = 0;
          m_rr     = (c + 1) % N;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_on) begin : compare
      int c;
      logic [N-1:0] er;
      c  = pick(req_valid);
      er = (reset_n && c >= 0 && !port_full) ? N'(1 << c) : '0;
      chk("m_ready", req_ready, er);
      chk("m_wren", port_wren, m_wren);
      chk("m_data", port_data, m_data);
      chk("m_owner", owner, m_owner);
      chk("m_locked", locked, m_locked);
      chk("m_stall", stall_count, m_stall);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 0; req_valid = '0; req_lock = '0; port_full = 0;
    for (int i = 0; i < N; i++) words[i] = {4'hA, 28'h0, 4'(i)};
    repeat (2) @(posedge clock);
    cmp_on = 1;
    @(negedge clock);
    chk("rst_wren", port_wren, 0);
    chk("rst_data", port_data, 0);
    chk("rst_owner", owner, 0);
    chk("rst_locked", locked, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_ready", req_ready, 0);
    step();

    // all four valid, no backpressure: strict rotation
    reset_n = 1; req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      chk("rot_ready", req_ready, 4'b0001 << (c % 4));
      if (c > 0) begin
        chk("rot_wren", port_wren, 1);
        chk("rot_data", port_data, words[(c - 1) % 4]);
      end
      step();
    end
    req_valid = '0;
    @(negedge clock);
    chk("rot_wren_last", port_wren, 1);
    chk("rot_data_last", port_data, words[3]);
    step();

    // port full for five cycles, then requester 2 goes through
    req_valid = 4'b0100; port_full = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("full_ready", req_ready, 0);
      step();
    end
    port_full = 0;
    @(negedge clock);
    chk("full_stall", stall_count, 5);
    chk("full_ready_release", req_ready, 4'b0100);
    step();
    req_valid = '0;
    @(negedge clock);
    chk("full_wren", port_wren, 1);
    chk("full_data", port_data, words[2]);
    step();

    // move pointer to 1, then a three-word burst from requester 1
    req_valid = 4'b0001;
    step();
    req_valid = 4'b1111; req_lock = 4'b0010;
    @(negedge clock);
    chk("burst_ready0", req_ready, 4'b0010);
    chk("burst_locked0", locked, 0);
    step();
    @(negedge clock);
    chk("burst_ready1", req_ready, 4'b0010);
    chk("burst_locked1", locked, 1);
    chk("burst_owner1", owner, 1);
    step();
    req_lock = '0;
    @(negedge clock);
    chk("burst_ready2", req_ready, 4'b0010);
    chk("burst_locked2", locked, 1);
    step();
    @(negedge clock);
    chk("burst_next", req_ready, 4'b0100);
    chk("burst_locked3", locked, 0);
    chk("burst_data", port_data, words[1]);
    step();

    // owner 3 locks, then goes quiet while others request
    req_valid = 4'b1000; req_lock = 4'b1000;
    step();
    req_valid = 4'b0111; req_lock = '0;
    for (int k = 0; k < 4; k++) begin
      port_full = (k >= 2);
      @(negedge clock);
      chk("hold_ready", req_ready, 0);
      chk("hold_locked", locked, 1);
      chk("hold_owner", owner, 3);
      chk("hold_stall", stall_count, 5);
      step();
    end
    port_full = 0; req_valid = 4'b1000;
    @(negedge clock);
    chk("hold_release", req_ready, 4'b1000);
    step();

    // reset in the middle of a burst from requester 1
    req_valid = 4'b0010; req_lock = 4'b0010;
    step();
    @(negedge clock);
    chk("mid_locked", locked, 1);
    chk("mid_owner", owner, 1);
    @(posedge clock);
    #2;
    reset_n = 0;
    #1;
    chk("mid_rst_wren", port_wren, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_owner", owner, 0);
    chk("mid_rst_stall", stall_count, 0);
    chk("mid_rst_ready", req_ready, 0);
    step();
    reset_n = 1; req_valid = 4'b1111; req_lock = '0;
    @(negedge clock);
    chk("mid_after", req_ready, 4'b0001);
    step();

    // saturation of the narrow stall counter
    req_valid = 4'b0001; port_full = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (k == 14) chk("sat_14", stall_count, 14);
      if (k == 15) chk("sat_15", stall_count, 15);
      step();
    end
    @(negedge clock);
    chk("sat_final", stall_count, 15);
    step();
    port_full = 0; req_valid = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin : rand_loop
      logic [63:0] r;
      if (!reset_n) reset_n = 1;
      else if ($urandom_range(0, 299) == 0) reset_n = 0;
      req_valid = N'($urandom);
      req_lock  = N'($urandom);
      port_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        r = {$urandom(), $urandom()};
        words[i] = r[W-1:0];
      end
      step();
    end
    @(negedge clock);
    cmp_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
